hub75_scan_driver: RTL and testbench

- Downstream consumer of the frame-buffer dual-port RAM: drives the RAM read port (address out, registered 8-bit data back one clock later) and converts the stored frame into HUB75 panel signals.
- Generates shift data, shift clock, latch, output enable and row address.
- Uses 3-plane binary-code modulation for 1/(ROWS/2) scan panels with upper and lower halves.
- Pixel byte format is RGB332: R=[7:5], G=[4:2], B=[1:0]. Blue is widened to 3 bits as {B[1:0],B[1]}.

---
 rtl/hub75_scan_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: reads a frame buffer and shifts it out as 3-plane BCM.
// Optional macro HUB75_BRIGHTNESS_EN adds a global brightness input gating output enable.
module hub75_scan_driver #(
  parameter int COLS        = 64,
  parameter int ROWS        = 32,
  parameter int BASE_CYCLES = 8,
  parameter int ROW_BITS    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]          brightness,
`endif
  output logic [15:0]         ram_addr,
  input  logic [7:0]          ram_data,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic                r2,
  output logic                g2,
  output logic                b2,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                panel_clk,
  output logic                panel_lat,
  output logic                panel_oe_n,
  output logic                frame_done
);

  localparam int SCAN  = ROWS / 2;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(BASE_CYCLES * 4) + 1;

  generate
    if (COLS * ROWS > 8192) begin : g_size_chk
      $error("hub75_scan_driver: COLS*ROWS must not exceed 8192");
    end
    if ((1 << ROW_BITS) != SCAN) begin : g_row_chk
      $error("hub75_scan_driver: ROW_BITS must equal log2(ROWS/2)");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_RD_TOP, S_RD_BOT, S_SET, S_CLK_HI, S_LATCH, S_SHOW
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [1:0]          plane_q, plane_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          top_q, top_d;
  logic [15:0]         addr_q, addr_d;
  logic [2:0]          rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
  logic                pclk_q, pclk_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic                done_q, done_d;
  logic [31:0]         show_len;
  logic                show_last;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]          bright_q, bright_d;
  logic [31:0]         show_thresh;
`endif

  // RGB332 widened to 3 bits per channel, then the current plane's bit of each
  function automatic logic [2:0] plane_bits(input logic [7:0] px, input logic [1:0] p);
    logic [2:0] r, g, b;
    r = px[7:5];
    g = px[4:2];
    b = {px[1:0], px[1]};
    return {r[p], g[p], b[p]};
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    plane_d    = plane_q;
    cnt_d      = cnt_q;
    top_d      = top_q;
    addr_d     = addr_q;
    rgb1_d     = rgb1_q;
    rgb2_d     = rgb2_q;
    row_addr_d = row_addr_q;
    pclk_d     = pclk_q;
    lat_d      = lat_q;
    oe_n_d     = 1'b1;
    done_d     = 1'b0;
    show_len   = 32'(BASE_CYCLES) << plane_q;
    show_last  = (32'(cnt_q) == show_len - 32'd1);
`ifdef HUB75_BRIGHTNESS_EN
    bright_d    = bright_q;
    show_thresh = (show_len * (32'(bright_q) + 32'd1)) >> 8;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RD_TOP;
      end
      S_RD_TOP: state_d = S_RD_BOT;
      S_RD_BOT: begin
        top_d   = ram_data;
        state_d = S_SET;
      end
      S_SET: begin
        rgb1_d  = plane_bits(top_q, plane_q);
        rgb2_d  = plane_bits(ram_data, plane_q);
        pclk_d  = 1'b0;
        state_d = S_CLK_HI;
      end
      S_CLK_HI: begin
        pclk_d = 1'b1;
        if (col_q == COL_W'(COLS - 1)) begin
          col_d   = '0;
          state_d = S_LATCH;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_RD_TOP;
        end
      end
      S_LATCH: begin
        pclk_d     = 1'b0;
        lat_d      = 1'b1;
        row_addr_d = row_q;
        cnt_d      = '0;
`ifdef HUB75_BRIGHTNESS_EN
        bright_d   = brightness;
`endif
        state_d    = S_SHOW;
      end
      S_SHOW: begin
        lat_d = 1'b0;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef HUB75_BRIGHTNESS_EN
        oe_n_d = !(32'(cnt_q) < show_thresh);
`else
        oe_n_d = 1'b0;
`endif
        if (show_last) begin
          if (plane_q == 2'd2) begin
            plane_d = '0;
            if (row_q == ROW_BITS'(SCAN - 1)) begin
              row_d  = '0;
              done_d = 1'b1;
            end else begin
              row_d = row_q + ROW_BITS'(1);
            end
          end else begin
            plane_d = plane_q + 2'd1;
          end
          state_d = enable ? S_RD_TOP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address is presented during the read state itself so data lands one clock later
    case (state_d)
      S_RD_TOP: addr_d = 16'(32'(row_d) * COLS + 32'(col_d));
      S_RD_BOT: addr_d = 16'((32'(row_q) + SCAN) * COLS + 32'(col_q));
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      cnt_q      <= '0;
      top_q      <= '0;
      addr_q     <= '0;
      rgb1_q     <= '0;
      rgb2_q     <= '0;
      row_addr_q <= '0;
      pclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      done_q     <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      cnt_q      <= cnt_d;
      top_q      <= top_d;
      addr_q     <= addr_d;
      rgb1_q     <= rgb1_d;
      rgb2_q     <= rgb2_d;
      row_addr_q <= row_addr_d;
      pclk_q     <= pclk_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
      done_q     <= done_d;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q   <= bright_d;
`endif
    end
  end

  assign ram_addr   = addr_q;
  assign r1         = rgb1_q[2];
  assign g1         = rgb1_q[1];
  assign b1         = rgb1_q[0];
  assign r2         = rgb2_q[2];
  assign g2         = rgb2_q[1];
  assign b2         = rgb2_q[0];
  assign row_addr   = row_addr_q;
  assign panel_clk  = pclk_q;
  assign panel_lat  = lat_q;
  assign panel_oe_n = oe_n_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver on a 4x4 panel: predicts shifted bits, latch rows,
// plane periods and display times from the frame contents.
module tb_hub75_scan_driver;
  localparam int COLS = 4, ROWS = 4, BASE = 2, RB = 1;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [15:0]   ram_addr;
  logic [7:0]    ram_data;
  logic          r1, g1, b1, r2, g2, b2;
  logic [RB-1:0] row_addr;
  logic          panel_clk, panel_lat, panel_oe_n, frame_done;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]    brightness;
`endif

  hub75_scan_driver #(.COLS(COLS), .ROWS(ROWS), .BASE_CYCLES(BASE), .ROW_BITS(RB)) dut (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .ram_addr(ram_addr), .ram_data(ram_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .panel_clk(panel_clk), .panel_lat(panel_lat),
    .panel_oe_n(panel_oe_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int mem [COLS*ROWS];
  always @(posedge clk) ram_data <= 8'(mem[ram_addr[3:0]]);

  int n_cmp = 0, n_bad = 0;
  int cycle = 0;
  logic prev_clk, prev_fd;
  logic [15:0] prev_addr;
  logic [5:0] edges[$];
  int lat_rows[$], lat_cyc[$], oe_runs[$], addr_log[$];
  int oe_run, fd_cnt, fd_wide, last_lat, last_n;
  int bright_v = 255;
  logic [2:0] col0_top;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    edges.delete(); lat_rows.delete(); lat_cyc.delete(); oe_runs.delete(); addr_log.delete();
    oe_run = 0; fd_cnt = 0; fd_wide = 0; last_lat = -1; last_n = 0;
    prev_clk = panel_clk; prev_fd = frame_done; prev_addr = 16'hFFFF;
  endtask

  // One clock, sampled 1ns after the edge, with panel events logged
  task automatic cyc();
    @(posedge clk); #1;
    cycle++;
    if (panel_clk && !prev_clk) edges.push_back({r1, g1, b1, r2, g2, b2});
    if (panel_lat) begin lat_rows.push_back(int'(row_addr)); lat_cyc.push_back(cycle); end
    if (!panel_oe_n) oe_run++;
    else if (oe_run > 0) begin oe_runs.push_back(oe_run); oe_run = 0; end
    if (frame_done) begin fd_cnt++; if (prev_fd) fd_wide++; end
    if (ram_addr !== prev_addr) addr_log.push_back(int'(ram_addr));
    prev_clk = panel_clk; prev_fd = frame_done; prev_addr = ram_addr;
  endtask

  function automatic logic [2:0] mbits(input int px, input int p);
    int r, g, b;
    r = px / 32;
    g = (px / 4) % 8;
    b = (px % 4) * 2 + (px / 2) % 2;
    return {((r >> p) & 1) != 0, ((g >> p) & 1) != 0, ((b >> p) & 1) != 0};
  endfunction

  function automatic logic [5:0] exp_edge(input int row, input int col, input int p);
    return {mbits(mem[row*COLS+col], p), mbits(mem[(row+ROWS/2)*COLS+col], p)};
  endfunction

  function automatic int exp_low(input int p);
    return ((BASE << p) * (bright_v + 1)) >> 8;
  endfunction

  task automatic expect_plane(input int row, input int p);
    int k, lc;
    logic [5:0] e;
    k = 0;
    while (oe_runs.size() == 0 && k < 400) begin cyc(); k++; end
    if (oe_runs.size() == 0) begin
      chk($sformatf("timeout r%0d p%0d", row, p), 0, 1);
      return;
    end
    chk($sformatf("edge count r%0d p%0d", row, p), edges.size(), COLS);
    for (int c = 0; c < COLS; c++) begin
      if (edges.size() > 0) begin
        e = edges.pop_front();
        if (c == 0) col0_top = e[5:3];
        chk($sformatf("shift r%0d p%0d c%0d", row, p, c), e, exp_edge(row, c, p));
      end
    end
    chk($sformatf("latch count r%0d p%0d", row, p), lat_rows.size(), 1);
    if (lat_rows.size() > 0) begin
      chk($sformatf("latch row r%0d p%0d", row, p), lat_rows.pop_front(), row);
      lc = lat_cyc.pop_front();
      if (last_lat >= 0) chk($sformatf("plane period r%0d p%0d", row, p), lc - last_lat, 4*COLS + 1 + last_n);
      last_lat = lc;
      last_n = BASE << p;
    end
    chk($sformatf("oe low r%0d p%0d", row, p), oe_runs.pop_front(), exp_low(p));
  endtask

  task automatic pulse_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0; clear_logs();
  endtask

  initial begin
    int k;
    int exp_addr [8];
    exp_addr = '{0, 8, 1, 9, 2, 10, 3, 11};
    reset = 1'b1; enable = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    for (int i = 0; i < COLS*ROWS; i++) mem[i] = int'($urandom_range(0, 255));
    cyc(); cyc();
    chk("rst ram_addr", ram_addr, 0);
    chk("rst rgb", {r1, g1, b1, r2, g2, b2}, 0);
    chk("rst row_addr", row_addr, 0);
    chk("rst panel_clk", panel_clk, 0);
    chk("rst panel_lat", panel_lat, 0);
    chk("rst panel_oe_n", panel_oe_n, 1);
    chk("rst frame_done", frame_done, 0);
    reset = 1'b0; clear_logs();

    // Top row all ones, bottom row all zeros
    for (int c = 0; c < COLS; c++) begin mem[c] = 8'hFF; mem[2*COLS+c] = 8'h00; end
    enable = 1'b1;
    expect_plane(0, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("addr seq %0d", i), (i < addr_log.size()) ? addr_log[i] : -1, exp_addr[i]);
    expect_plane(0, 1);
    expect_plane(0, 2);
    chk("no frame_done mid frame", fd_cnt, 0);
    for (int p = 0; p < 3; p++) expect_plane(1, p);
    chk("frame_done count", fd_cnt, 1);
    chk("frame_done width", fd_wide, 0);
    expect_plane(0, 0);
    expect_plane(0, 1);
    expect_plane(0, 2);
    expect_plane(1, 0);

    // Reset while the row-1 plane-1 display is active
    k = 0;
    while (panel_oe_n && k < 200) begin cyc(); k++; end
    chk("reached show", panel_oe_n, 0);
    chk("show row", row_addr, 1);
    reset = 1'b1; enable = 1'b0;
    cyc();
    chk("midrst oe_n", panel_oe_n, 1);
    chk("midrst lat", panel_lat, 0);
    chk("midrst row_addr", row_addr, 0);
    chk("midrst ram_addr", ram_addr, 0);
    chk("midrst clk", panel_clk, 0);
    reset = 1'b0; clear_logs();
    repeat (12) cyc();
    chk("idle no edges", edges.size(), 0);
    chk("idle oe_n", panel_oe_n, 1);
    chk("idle ram_addr", ram_addr, 0);

    // Pixel 0xB6 at top col 0: every channel reads 1,0,1 across planes
    for (int i = 0; i < COLS*ROWS; i++) mem[i] = int'($urandom_range(0, 255));
    mem[0] = 8'hB6;
    enable = 1'b1;
    expect_plane(0, 0); chk("b6 plane0", col0_top, 3'b111);
    expect_plane(0, 1); chk("b6 plane1", col0_top, 3'b000);
    expect_plane(0, 2); chk("b6 plane2", col0_top, 3'b111);
    expect_plane(1, 0);
    enable = 1'b0;
    expect_plane(1, 1);
    repeat (40) cyc();
    chk("stop no edges", edges.size(), 0);
    chk("stop no latch", lat_rows.size(), 0);
    chk("stop no display", oe_runs.size() + oe_run, 0);
    chk("stop oe_n", panel_oe_n, 1);

    for (int f = 0; f < 3; f++) begin
      pulse_reset();
      for (int i = 0; i < COLS*ROWS; i++) mem[i] = int'($urandom_range(0, 255));
      enable = 1'b1;
      for (int r = 0; r < ROWS/2; r++)
        for (int p = 0; p < 3; p++) expect_plane(r, p);
      chk($sformatf("rand frame_done %0d", f), fd_cnt, 1);
      enable = 1'b0;
    end

`ifdef HUB75_BRIGHTNESS_EN
    pulse_reset();
    bright_v = 127; brightness = 8'd127;
    enable = 1'b1;
    for (int r = 0; r < ROWS/2; r++)
      for (int p = 0; p < 3; p++) expect_plane(r, p);
    enable = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
